seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_pkg.sv | 27 ++
 rtl/seg_glyph_decode.sv | 30 +++
 rtl/seven_seg_scanner.sv | 123 ++++++++++++
 tb/tb_seven_seg_scanner.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared glyph codes and segment patterns for the multiplexed seven-segment scanner.
// Segment order is {a,b,c,d,e,f,g} with segment a at the MSB; a set bit lights the segment.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam logic [3:0] BLANK   = 4'd10;
  localparam logic [3:0] DASH    = 4'd11;
  localparam logic [3:0] GLYPH_A = 4'd12;
  localparam logic [3:0] GLYPH_P = 4'd13;

  localparam seg_t SEG_0    = 7'b1111110;
  localparam seg_t SEG_1    = 7'b0110000;
  localparam seg_t SEG_2    = 7'b1101101;
  localparam seg_t SEG_3    = 7'b1111001;
  localparam seg_t SEG_4    = 7'b0110011;
  localparam seg_t SEG_5    = 7'b1011011;
  localparam seg_t SEG_6    = 7'b1011111;
  localparam seg_t SEG_7    = 7'b1110000;
  localparam seg_t SEG_8    = 7'b1111111;
  localparam seg_t SEG_9    = 7'b1111011;
  localparam seg_t SEG_OFF  = 7'b0000000;
  localparam seg_t SEG_DASH = 7'b0000001;
  localparam seg_t SEG_A    = 7'b1110111;
  localparam seg_t SEG_P    = 7'b1100111;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational 4-bit glyph code to 7-segment pattern decode.
// Codes 14 and 15 are unassigned and fall through to blank.
module seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_code)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      BLANK:   o_seg = SEG_OFF;
      DASH:    o_seg = SEG_DASH;
      GLYPH_A: o_seg = SEG_A;
      GLYPH_P: o_seg = SEG_P;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment driver: prescaled digit scan, frame-coherent shadow
// registers, blink, leading-zero suppression and registered segment/anode outputs.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 256,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [4*DIGITS-1:0] codes,
  input  logic [DIGITS-1:0]   dp_mask,
  input  logic [DIGITS-1:0]   blink_mask,
  input  logic                lz_en,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   an
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [PRE_W-1:0]    r_presc;
  logic [IDX_W-1:0]    r_idx;
  logic [BLK_W-1:0]    r_blk_cnt;
  logic                r_blink;
  logic                r_frame_vld;
  logic [4*DIGITS-1:0] r_sh_codes;
  logic [DIGITS-1:0]   r_sh_dp;
  logic [DIGITS-1:0]   r_sh_blink;

  logic [6:0]          r_seg_p1;
  logic                r_dp_p1;
  logic [DIGITS-1:0]   r_an_p1;

  logic                w_tick;
  logic                w_wrap;
  logic [DIGITS-1:0]   w_lz_blank;
  logic [3:0]          w_code_p0;
  logic [6:0]          w_glyph_p0;
  logic                w_blank_p0;
  logic [DIGITS-1:0]   w_onehot_p0;

  assign w_tick = (r_presc == PRE_LAST);
  assign w_wrap = w_tick && (r_idx == LAST_IDX);

  // r_frame_vld keeps the anodes dark until the shadows hold a real frame after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_blk_cnt   <= '0;
      r_blink     <= 1'b0;
      r_frame_vld <= 1'b0;
      r_sh_codes  <= {DIGITS{BLANK}};
      r_sh_dp     <= '0;
      r_sh_blink  <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx     <= w_wrap ? '0 : r_idx + 1'b1;
        r_blk_cnt <= (r_blk_cnt == BLK_LAST) ? '0 : r_blk_cnt + 1'b1;
        if (r_blk_cnt == BLK_LAST) r_blink <= ~r_blink;
      end
      if (w_wrap) begin
        r_sh_codes  <= codes;
        r_sh_dp     <= dp_mask;
        r_sh_blink  <= blink_mask;
        r_frame_vld <= 1'b1;
      end
    end
  end

  // Suppression runs from the most significant digit down; digit 0 is never blanked.
  always_comb begin : p_lz
    logic v_run;
    v_run      = lz_en;
    w_lz_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      v_run         = v_run && (r_sh_codes[4*i +: 4] == 4'd0);
      w_lz_blank[i] = v_run;
    end
  end

  always_comb begin
    w_onehot_p0 = '0;
    for (int i = 0; i < DIGITS; i++) w_onehot_p0[i] = (r_idx == IDX_W'(i));
  end

  assign w_code_p0  = r_sh_codes[4*r_idx +: 4];
  assign w_blank_p0 = w_lz_blank[r_idx] | (r_blink & r_sh_blink[r_idx]);

  seg_glyph_decode u_decode (
    .i_code (w_code_p0),
    .o_seg  (w_glyph_p0)
  );

  // p0 -> p1: everything below is taken from the same r_idx value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg_p1 <= '0;
      r_dp_p1  <= 1'b0;
      r_an_p1  <= '0;
    end else begin
      r_seg_p1 <= w_blank_p0 ? '0 : w_glyph_p0;
      r_dp_p1  <= r_sh_dp[r_idx] & ~w_blank_p0;
      r_an_p1  <= (en && r_frame_vld) ? w_onehot_p0 : '0;
    end
  end

  assign seg = (ACTIVE_LOW != 0) ? ~r_seg_p1 : r_seg_p1;
  assign dp  = (ACTIVE_LOW != 0) ? ~r_dp_p1  : r_dp_p1;
  assign an  = (ACTIVE_LOW != 0) ? ~r_an_p1  : r_an_p1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: two instances (active-high and active-low) on shared inputs,
// one 16-cycle frame per table vector, expectations queued per sample and popped on negedges.
module tb_seven_seg_scanner;

  localparam logic [6:0] S0   = 7'b1111110;
  localparam logic [6:0] S1   = 7'b0110000;
  localparam logic [6:0] S2   = 7'b1101101;
  localparam logic [6:0] S3   = 7'b1111001;
  localparam logic [6:0] S4   = 7'b0110011;
  localparam logic [6:0] S5   = 7'b1011011;
  localparam logic [6:0] S6   = 7'b1011111;
  localparam logic [6:0] S7   = 7'b1110000;
  localparam logic [6:0] S8   = 7'b1111111;
  localparam logic [6:0] S9   = 7'b1111011;
  localparam logic [6:0] OFF  = 7'b0000000;
  localparam logic [6:0] DSH  = 7'b0000001;
  localparam logic [6:0] SA   = 7'b1110111;
  localparam logic [6:0] SP   = 7'b1100111;
  localparam int         NV   = 13;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        en         = 1'b1;
  logic        lz_en      = 1'b0;
  logic [15:0] codes      = 16'h1234;
  logic [3:0]  dp_mask    = 4'b0000;
  logic [3:0]  blink_mask = 4'b0000;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;
  logic [3:0]  an0, an1;

  seven_seg_scanner #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .reset(reset), .en(en), .codes(codes), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .lz_en(lz_en), .seg(seg0), .dp(dp0), .an(an0)
  );

  seven_seg_scanner #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .reset(reset), .en(en), .codes(codes), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .lz_en(lz_en), .seg(seg1), .dp(dp1), .an(an1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     codes;
    logic [3:0]      dpm;
    logic [3:0]      blm;
    logic            lz;
    logic            en;
    logic [3:0][6:0] eseg;
    logic [3:0]      edp;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         tag;
  } exp_t;

  vec_t vecs[NV];
  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  logic found;

  task automatic cmp(input string nm, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual={an,seg,dp}=%03h required=%03h", nm, act, req);
    end
  endtask

  task automatic check_both(input string nm, input logic [3:0] an_e, input logic [6:0] seg_e,
                            input logic dp_e);
    cmp({nm, "_hi"}, {an0, seg0, dp0}, {an_e, seg_e, dp_e});
    cmp({nm, "_lo"}, {an1, seg1, dp1}, ~{an_e, seg_e, dp_e});
  endtask

  task automatic push_frame(input int k, input logic en_v, input logic [3:0][6:0] es,
                            input logic [3:0] ed);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        e.an  = en_v ? (4'b0001 << d) : 4'b0000;
        e.seg = es[d];
        e.dp  = ed[d];
        e.tag = k * 10 + d;
        q.push_back(e);
      end
    end
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty actual=0 entries required=1 entry");
      end else begin
        mon_e = q.pop_front();
        check_both($sformatf("frame%0d_dig%0d", mon_e.tag / 10, mon_e.tag % 10),
                   mon_e.an, mon_e.seg, mon_e.dp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // codes, dp_mask, blink_mask, lz_en, en, segs {d3,d2,d1,d0}, dp {d3..d0}
    vecs[0]  = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b1, {S1, S2, S3, S4},     4'b0000};
    vecs[1]  = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 1'b1, {OFF, OFF, S5, S0},   4'b0000};
    vecs[2]  = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b1, {OFF, OFF, OFF, S0},  4'b0000};
    vecs[3]  = '{16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1, {S0, S0, S0, S0},     4'b0000};
    vecs[4]  = '{16'h1111, 4'b0010, 4'b0000, 1'b1, 1'b1, {S1, S1, S1, S1},     4'b0010};
    vecs[5]  = '{16'h2222, 4'b0000, 4'b0000, 1'b1, 1'b1, {S2, S2, S2, S2},     4'b0000};
    // Phase is 0 in the digit 0/1 slots and 1 in the digit 2/3 slots of every frame.
    vecs[6]  = '{16'h00C8, 4'b0000, 4'b0001, 1'b1, 1'b1, {OFF, OFF, SA, S8},   4'b0000};
    vecs[7]  = '{16'h8888, 4'b1111, 4'b1100, 1'b0, 1'b1, {OFF, OFF, S8, S8},   4'b0011};
    vecs[8]  = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0, {S1, S2, S3, S4},     4'b0000};
    vecs[9]  = '{16'h1234, 4'b1000, 4'b0000, 1'b0, 1'b1, {S1, S2, S3, S4},     4'b1000};
    vecs[10] = '{16'hABCD, 4'b0000, 4'b0000, 1'b1, 1'b1, {OFF, DSH, SA, SP},   4'b0000};
    vecs[11] = '{16'h0E0F, 4'b0000, 4'b0000, 1'b1, 1'b1, {OFF, OFF, S0, OFF},  4'b0000};
    vecs[12] = '{16'h0967, 4'b0000, 4'b0000, 1'b1, 1'b1, {OFF, S9, S6, S7},    4'b0000};

    repeat (3) @(negedge clk);
    check_both("reset_state", 4'b0000, OFF, 1'b0);

    push_frame(0, 1'b0, {OFF, OFF, OFF, OFF}, 4'b0000);
    reset = 1'b0;
    cyc   = 0;
    @(posedge clk);
    mon_en = 1'b1;

    for (int v = 0; v < NV; v++) begin
      tick_to(16 * (v + 1) - 8);
      codes      = vecs[v].codes;
      dp_mask    = vecs[v].dpm;
      blink_mask = vecs[v].blm;
      push_frame(v + 1, vecs[v].en, vecs[v].eseg, vecs[v].edp);
      tick_to(16 * (v + 1));
      en    = vecs[v].en;
      lz_en = vecs[v].lz;
    end
    tick_to(16 * (NV + 1));
    @(posedge clk);
    mon_en = 1'b0;
    cmp("sb_drained", 12'(q.size()), 12'd0);

    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an0 == 4'b0100) begin
        found = 1'b1;
        break;
      end
    end
    cmp("find_digit2", {11'd0, found}, 12'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check_both("reset_async", 4'b0000, OFF, 1'b0);

    codes      = 16'h1234;
    lz_en      = 1'b0;
    en         = 1'b1;
    dp_mask    = 4'b0000;
    blink_mask = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1 || i == 8 || i == 16) check_both($sformatf("restart_blank_c%0d", i), 4'b0000, OFF, 1'b0);
    end
    @(negedge clk);
    check_both("restart_d0", 4'b0001, S4, 1'b0);
    repeat (4) @(negedge clk);
    check_both("restart_d1", 4'b0010, S3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
